// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the F/D/E/M/W pipeline: operand forwarding, load-use and
// PC-write stalls/flushes, plus a wait-state FSM freezing the pipe on slow data memory.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemStall,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WC_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            timeout;
    logic            ldr_stall;
    logic            pc_wr_pending;

    // Register 15 is the PC and is never forwarded; M is the younger result so it wins.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RA1E == WA3M && RA1E != 4'd15)      ForwardAE = 2'b10;
        else if (RegWriteW && RA1E == WA3W && RA1E != 4'd15) ForwardAE = 2'b01;
        if (RegWriteM && RA2E == WA3M && RA2E != 4'd15)      ForwardBE = 2'b10;
        else if (RegWriteW && RA2E == WA3W && RA2E != 4'd15) ForwardBE = 2'b01;
    end

    assign ldr_stall     = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    // A request withdrawn mid-wait is treated as completion.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        MemStall     = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (MemReqM && !MemAckM) begin
                    MemStall     = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            WAIT: begin
                if (MemAckM || !MemReqM) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
                    timeout      = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    MemStall     = 1'b1;
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // A memory wait freezes every stage and bubbles W; hazards are re-evaluated after release.
    always_comb begin
        if (MemStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall | pc_wr_pending;
            StallD = ldr_stall;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = pc_wr_pending | PCSrcW | BranchTakenE;
            FlushE = ldr_stall | BranchTakenE;
            FlushW = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            MemErr     <= 1'b0;
            StallCount <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout) MemErr <= 1'b1;
            if (StallF && StallCount != {CNT_W{1'b1}}) StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed checks of pipeline_hazard_ctrl against a cycle-level
// behavioural model (integer stall-run tracking, saturating integer counter).
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemAckM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic          MemStall, MemErr;
    logic [CW-1:0] StallCount;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemStall(MemStall), .MemErr(MemErr), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state: stall cycles already spent on the current access, sticky error, stall counter
    int run;
    bit err;
    int cnt;
    bit last_ms;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [3:0] ra, input logic [3:0] wm, input logic rwm,
                                       input logic [3:0] ww, input logic rww);
        if (ra == 4'd15)           return 2'b00;
        if (rwm && ra == wm)       return 2'b10;
        if (rww && ra == ww)       return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemAckM} = '0;
    endtask

    // Called just after a negedge with inputs applied; checks, then advances one clock.
    task automatic step();
        bit ldr, pcw, ms, sf, sd, se, sm, fd, fe, fw;
        #1;
        ldr = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
        pcw = PCSrcD || PCSrcE || PCSrcM;
        ms  = MemReqM && !MemAckM && (run < TO);
        if (ms) begin
            {sf, sd, se, sm, fw} = 5'b11111;
            {fd, fe} = 2'b00;
        end else begin
            sf = ldr || pcw;
            sd = ldr;
            {se, sm, fw} = 3'b000;
            fd = pcw || PCSrcW || BranchTakenE;
            fe = ldr || BranchTakenE;
        end
        last_ms = ms;
        chk("ForwardAE", 32'(ForwardAE), 32'(fwd(RA1E, WA3M, RegWriteM, WA3W, RegWriteW)));
        chk("ForwardBE", 32'(ForwardBE), 32'(fwd(RA2E, WA3M, RegWriteM, WA3W, RegWriteW)));
        chk("MemStall", 32'(MemStall), 32'(ms));
        chk("StallF", 32'(StallF), 32'(sf));
        chk("StallD", 32'(StallD), 32'(sd));
        chk("StallE", 32'(StallE), 32'(se));
        chk("StallM", 32'(StallM), 32'(sm));
        chk("FlushD", 32'(FlushD), 32'(fd));
        chk("FlushE", 32'(FlushE), 32'(fe));
        chk("FlushW", 32'(FlushW), 32'(fw));
        chk("MemErr", 32'(MemErr), 32'(err));
        chk("StallCount", 32'(StallCount), 32'(cnt));
        @(posedge clk);
        if (reset) begin
            run = 0;
            err = 0;
            cnt = 0;
        end else begin
            if (run == TO && MemReqM && !MemAckM) err = 1;
            run = ms ? run + 1 : 0;
            if (sf && cnt < (1 << CW) - 1) cnt++;
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        int stalls;
        clear_inputs();
        reset = 1'b1;
        run = 0; err = 0; cnt = 0;
        @(posedge clk);
        @(negedge clk);
        step();                       // reset held, all inputs 0: every output 0
        reset = 1'b0;

        // forwarding: M beats W, r15 never forwarded
        RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 15;
        #1;
        chk("fwd_m_prio", 32'(ForwardAE), 32'd2);
        chk("fwd_r15", 32'(ForwardBE), 32'd0);
        step();
        RegWriteM = 0;
        #1;
        chk("fwd_w", 32'(ForwardAE), 32'd1);
        step();

        // load-use, then load-use with taken branch, then PC write in D
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
        repeat (3) step();
        BranchTakenE = 1;
        #1;
        chk("ldr_br_flushd", 32'(FlushD), 32'd1);
        chk("ldr_br_stalld", 32'(StallD), 32'd1);
        step();
        clear_inputs();
        PCSrcD = 1;
        #1;
        chk("pcsrcd_flushe", 32'(FlushE), 32'd0);
        step();

        // ack on the third cycle of a request: two stall cycles
        clear_inputs();
        MemReqM = 1;
        stalls = 0;
        for (int c = 0; c < 3; c++) begin
            MemAckM = (c == 2);
            step();
            stalls += int'(last_ms);
        end
        chk("ack3_stalls", 32'(stalls), 32'd2);
        chk("ack3_memerr", 32'(MemErr), 32'd0);
        clear_inputs();
        step();

        // no ack: TO stall cycles, released in the next, sticky error afterwards
        MemReqM = 1;
        stalls = 0;
        for (int c = 0; c < TO; c++) begin
            step();
            stalls += int'(last_ms);
        end
        chk("to_stalls", 32'(stalls), 32'(TO));
        chk("to_release", 32'(MemStall), 32'd0);
        step();
        MemReqM = 0;
        #1;
        chk("to_memerr", 32'(MemErr), 32'd1);
        repeat (2) step();
        chk("memerr_sticky", 32'(MemErr), 32'd1);

        // reset during the second wait cycle
        MemReqM = 1;
        step();
        reset = 1;
        step();
        reset = 0; MemReqM = 0;
        #1;
        chk("rst_memstall", 32'(MemStall), 32'd0);
        chk("rst_memerr", 32'(MemErr), 32'd0);
        chk("rst_cnt", 32'(StallCount), 32'd0);
        step();

        // counter saturation
        PCSrcD = 1;
        repeat (20) step();
        chk("cnt_sat", 32'(StallCount), 32'd15);

        // randomized traffic with occasional reset
        clear_inputs();
        for (int i = 0; i < 2000; i++) begin
            RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
            WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemtoRegE = ($urandom_range(0, 2) == 0);
            PCSrcD = ($urandom_range(0, 5) == 0); PCSrcE = ($urandom_range(0, 5) == 0);
            PCSrcM = ($urandom_range(0, 5) == 0); PCSrcW = ($urandom_range(0, 5) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            if (MemReqM) MemReqM = ($urandom_range(0, 7) != 0);
            else         MemReqM = ($urandom_range(0, 3) == 0);
            MemAckM = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W). It generates the stall, flush and forwarding controls that drive the stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It covers load-use, branch and PC-write hazards. It also runs a wait-state FSM that freezes the pipeline while a data-memory access in M is unacknowledged, with timeout and stall-cycle accounting.

Parameters:
MEM_TIMEOUT, 8, max stall cycles for one M-stage memory access before abandon (>=1)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
RA1D  in  4  Rn source register in D
RA2D  in  4  Rm/Rd source register in D
RA1E  in  4  Rn source register in E
RA2E  in  4  Rm source register in E
WA3E  in  4  destination register in E
WA3M  in  4  destination register in M
WA3W  in  4  destination register in W
RegWriteE  in  1  E writes register file
RegWriteM  in  1  M writes register file
RegWriteW  in  1  W writes register file
MemtoRegE  in  1  E instruction is a load
PCSrcD  in  1  D instruction writes PC
PCSrcE  in  1  E instruction writes PC
PCSrcM  in  1  M instruction writes PC
PCSrcW  in  1  W instruction writes PC
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  M instruction accesses data memory
MemAckM  in  1  data memory completes access this cycle
ForwardAE  out  2  SrcA mux: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB mux, same encoding
StallF  out  1  hold PC register
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushW  out  1  insert bubble into MEM/WB
MemStall  out  1  memory wait active
MemErr  out  1  sticky: an access timed out
StallCount  out  CNT_W  cycles with StallF=1, saturating

Behaviour:
- Forwarding (combinational), per operand X in {A,B} using RA1E/RA2E:
  - 10 if RegWriteM & RAxE==WA3M & RAxE!=15.
  - else 01 if RegWriteW & RAxE==WA3W & RAxE!=15.
  - else 00. M has priority over W.
- LDRstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
- PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Memory FSM, states IDLE and WAIT, 4-bit-min counter WaitCnt (width ceil(log2(MEM_TIMEOUT+1))):
  - IDLE: MemReqM & ~MemAckM gives MemStall=1 and next state WAIT with WaitCnt=1. Otherwise MemStall=0 and stay in IDLE.
  - WAIT with MemAckM: MemStall=0, next IDLE, WaitCnt=0.
  - WAIT with ~MemAckM & WaitCnt==MEM_TIMEOUT: MemStall=0, MemErr<=1, next IDLE, WaitCnt=0. The access is abandoned and the pipeline proceeds.
  - WAIT otherwise: MemStall=1, WaitCnt++.
  - Max MemStall run per access = MEM_TIMEOUT cycles. An ack in the same cycle as the request costs 0 stall cycles.
  - MemReqM dropping while in WAIT is treated as an ack.
- Outputs when MemStall=1 (overrides everything else):
  - StallF=StallD=StallE=StallM=1.
  - FlushW=1.
  - FlushD=FlushE=0.
  - Forwarding is still computed.
- Outputs when MemStall=0:
  - StallE=StallM=FlushW=0.
  - StallF = LDRstall | PCWrPendingF.
  - StallD = LDRstall.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- Registered state (MemErr, StallCount, FSM):
  - StallCount increments each cycle StallF=1 and saturates at all-ones.
  - MemErr stays 1 until reset.
- Reset (synchronous, including mid-WAIT): state=IDLE, WaitCnt=0, MemErr=0, StallCount=0.
  - A reset during WAIT drops MemStall on the following cycle regardless of MemAckM.
  - Combinational outputs follow their inputs; with all inputs 0, every output is 0.
- Simultaneous events:
  - LDRstall with BranchTakenE: StallD=1, FlushD=1, FlushE=1. Flush wins at IF/ID.
  - Load-use arising during MemStall is held frozen and re-evaluated after release.

Test Plan:
- RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=15 -> ForwardAE=10, ForwardBE=00; drop RegWriteM -> ForwardAE=01.
- MemtoRegE=RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0, StallCount +1 per cycle.
- BranchTakenE=1 with load-use active -> FlushD=FlushE=1, StallD=1; PCSrcD=1 alone -> StallF=1, FlushD=1, FlushE=0.
- MEM_TIMEOUT=8, MemReqM=1, MemAckM asserted on 3rd cycle -> MemStall high exactly 2 cycles, StallE/StallM/FlushW=1 in those cycles, MemErr=0.
- MEM_TIMEOUT=4, MemReqM=1, no ack -> MemStall high exactly 4 cycles, 0 in 5th, MemErr=1 from next edge and sticky.
- Reset asserted in WAIT cycle 2 -> next cycle MemStall=0, MemErr=0, StallCount=0; StallCount with CNT_W=4 held stalled 20 cycles -> saturates at 15.
